led_scan_mux: RTL

//  Time-multiplexed digit scanner for the common-anode 7-segment display bank.
//  - Captures a packed hex word on a load strobe.
//  - Cycles through the digits at a programmable refresh rate.
//  - Per slot, drives the digit's nibble, decimal point and enable to the downstream
//    hex-to-segment decoder, plus one-hot active-low anode selects.
//  - Double-buffers the value (no tearing) and optionally blanks leading zeros.

---
 rtl/led_scan_mux.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/led_scan_mux.sv
// led_scan_mux: time-multiplexed scanner for a common-anode 7-segment bank.
// A packed hex word is captured into a shadow register on a load strobe and
// promoted to the active register only at frame boundaries, so a frame never
// mixes old and new digits. Each digit slot starts with an all-anodes-off
// ghost window. Leading zeros can optionally be blanked. All outputs are
// registered.
module led_scan_mux #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int GHOST_CYC   = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          load,
   input  logic [4*NUM_DIGITS-1:0]       value,
   input  logic [NUM_DIGITS-1:0]         dp_mask,
   input  logic                          blank_lz,
   output logic [3:0]                    hex,
   output logic                          dp,
   output logic                          en,
   output logic [NUM_DIGITS-1:0]         an,
   output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

   localparam int IW = $clog2(NUM_DIGITS);
   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   // scan position
   logic [CW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] idx_q, idx_d;

   // shadow (written by load) and active (displayed) copies of the word
   logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
   logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
   logic [4*NUM_DIGITS-1:0] active_val_q, active_val_d;
   logic [NUM_DIGITS-1:0]   active_dp_q, active_dp_d;

   // registered outputs
   logic [3:0]            hex_q, hex_d;
   logic                  dp_q, dp_d;
   logic                  en_q, en_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [IW-1:0]         out_idx_q, out_idx_d;

   logic [3:0]            nib [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] used;
   logic [IW-1:0]         lead_k;
   logic                  cnt_term;
   logic                  frame_end;
   logic                  ghost;

   // a digit is "used" if it shows a nonzero nibble or a lit decimal point
   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         assign nib[gi]  = active_val_q[gi*4 +: 4];
         assign used[gi] = (nib[gi] != 4'h0) | active_dp_q[gi];
      end
   endgenerate

   assign cnt_term  = (cnt_q == CW'(REFRESH_DIV - 1));
   assign frame_end = cnt_term && (idx_q == IW'(NUM_DIGITS - 1));
   assign ghost     = (int'(cnt_q) < GHOST_CYC);

   // highest used digit; digits above it are leading zeros
   always_comb begin
      lead_k = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (used[i]) lead_k = IW'(i);
      end
   end

   // next-state: refresh counter, digit index, shadow/active buffers
   always_comb begin
      cnt_d        = cnt_q + CW'(1);
      idx_d        = idx_q;
      shadow_val_d = shadow_val_q;
      shadow_dp_d  = shadow_dp_q;
      active_val_d = active_val_q;
      active_dp_d  = active_dp_q;
      if (cnt_term) begin
         cnt_d = '0;
         idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
      end
      if (load) begin
         shadow_val_d = value;
         shadow_dp_d  = dp_mask;
      end
      // a load landing on the boundary goes straight into the new frame
      if (frame_end) begin
         active_val_d = load ? value   : shadow_val_q;
         active_dp_d  = load ? dp_mask : shadow_dp_q;
      end
   end

   // next outputs: hex/dp track the digit immediately, anode/enable wait out the ghost window
   always_comb begin
      hex_d     = nib[idx_q];
      dp_d      = ~active_dp_q[idx_q];
      out_idx_d = idx_q;
      an_d      = '1;
      en_d      = 1'b0;
      if (!ghost) begin
         an_d[idx_q] = 1'b0;
         en_d        = !(blank_lz && (idx_q > lead_k));
      end
   end

   // state and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         shadow_val_q <= '0;
         shadow_dp_q  <= '0;
         active_val_q <= '0;
         active_dp_q  <= '0;
         hex_q        <= 4'h0;
         dp_q         <= 1'b1;
         en_q         <= 1'b0;
         an_q         <= '1;
         out_idx_q    <= '0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shadow_val_q <= shadow_val_d;
         shadow_dp_q  <= shadow_dp_d;
         active_val_q <= active_val_d;
         active_dp_q  <= active_dp_d;
         hex_q        <= hex_d;
         dp_q         <= dp_d;
         en_q         <= en_d;
         an_q         <= an_d;
         out_idx_q    <= out_idx_d;
      end
   end

   assign hex       = hex_q;
   assign dp        = dp_q;
   assign en        = en_q;
   assign an        = an_q;
   assign digit_idx = out_idx_q;

endmodule
